// File: rtl/nv_fifo_ctrl_rws_32x32.sv
// Purpose : valid/ready FIFO controller driving an external 1W/1R RAM whose read
//           address is registered and whose read data is held until the next read.
// Latency : push at cycle N -> RAM fetch at N+1 earliest -> rd_pvld at N+2; 1 push + 1 pop per cycle.
// Backpr. : wr_prdy is a registered "not full" flag, so a pop while full frees the
//           slot for a push only on the following cycle; rd_prdy=0 holds the presented word.
//
// Ports:
//   clk, reset         core clock (shared with RAM), asynchronous active-high reset
//   wr_pvld/prdy/pd    write side handshake and payload
//   rd_pvld/prdy/pd    read side handshake and payload (rd_pd is ram_dout, unregistered)
//   ram_we/wa/di       RAM write port
//   ram_re/ra          RAM read address capture
//   ram_dout           RAM read data (valid the cycle after ram_re, held until next ram_re)
//   fifo_level         occupancy 0..DEPTH
//
// Build option: define NV_FIFO_CTRL_LEVEL_EN to build the fifo_level register;
// otherwise fifo_level is tied to zero and no level register exists.

module nv_fifo_ctrl_rws_32x32 #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic [AW:0]   fifo_level
);

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so that equal address bits with a
  // differing MSB mean "full" rather than "empty".
  logic [AW:0] wr_ptr;      // next slot to write
  logic [AW:0] rd_ptr;      // next slot to fetch from RAM
  logic [AW:0] pop_cnt;     // entries handed downstream
  logic        out_valid;   // a fetched word is being presented on rd_pd

  logic        push;
  logic        pop;
  logic        fetch;

  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;
  logic [AW:0] pop_cnt_nxt;
  logic [AW:0] occ_nxt;
  logic        out_valid_nxt;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign push = wr_pvld & wr_prdy;
  assign pop  = out_valid & rd_prdy;

  // A new word can be fetched whenever unfetched entries exist and the output
  // stage is free or being emptied this cycle, which gives bubble-free popping.
  assign fetch = (rd_ptr != wr_ptr) & (~out_valid | pop);

  // ---------------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    pop_cnt_nxt   = pop_cnt;
    out_valid_nxt = out_valid;

    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
    end
    if (fetch) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
    if (pop) begin
      pop_cnt_nxt = pop_cnt + PTR_ONE;
    end

    out_valid_nxt = fetch | (out_valid & ~pop);
  end

  // Occupancy counts from the last popped entry, so the word currently shown
  // downstream still owns its RAM slot; that slot can therefore never be
  // rewritten while rd_pd is reading it through the registered RAM address.
  assign occ_nxt = wr_ptr_nxt - pop_cnt_nxt;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_cnt   <= '0;
      out_valid <= 1'b0;
      wr_prdy   <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      pop_cnt   <= pop_cnt_nxt;
      out_valid <= out_valid_nxt;
      // Registered so the write side never sees a combinational path from rd_prdy.
      wr_prdy   <= (occ_nxt != FULL_OCC);
    end
  end

  // ---------------------------------------------------------------------------
  // RAM ports
  // ---------------------------------------------------------------------------
  assign ram_we = push;
  assign ram_wa = wr_ptr[AW-1:0];
  assign ram_di = wr_pd;

  assign ram_re = fetch;
  assign ram_ra = rd_ptr[AW-1:0];

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  assign rd_pvld = out_valid;
  // The RAM holds its output until the next ram_re, and ram_re is suppressed
  // while a word is stalled, so rd_pd stays stable without a local data flop.
  assign rd_pd   = ram_dout;

  // ---------------------------------------------------------------------------
  // Optional occupancy output
  // ---------------------------------------------------------------------------
`ifdef NV_FIFO_CTRL_LEVEL_EN
  logic [AW:0] level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + PTR_ONE;
        2'b01:   level_q <= level_q - PTR_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  assign fifo_level = level_q;
`else
  assign fifo_level = '0;
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_rws_32x32.sv
// Bench for nv_fifo_ctrl_rws_32x32 with a behavioural RAM and a queue-based
// reference model: each entry becomes visible two cycles after its push, or
// one cycle after the previous entry leaves, whichever is later.
module tb_nv_fifo_ctrl_rws_32x32;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   fifo_level;

  nv_fifo_ctrl_rws_32x32 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_dout(ram_dout),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // RAM: registered read address, data read combinationally from it.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  // Reference model
  typedef struct { logic [DW-1:0] d; int pc; } ent_t;
  ent_t q[$];
  int t, front_ready, push_total, fetch_total;

  logic          exp_wr_prdy, exp_rd_pvld, exp_we, exp_re;
  logic [DW-1:0] exp_rd_pd;
  logic [AW-1:0] exp_wa, exp_ra;
  logic [AW:0]   exp_level;

  logic          obs_wr_prdy, obs_rd_pvld, obs_we, obs_re;
  logic [DW-1:0] obs_rd_pd, obs_di;
  logic [AW-1:0] obs_wa, obs_ra;
  logic [AW:0]   obs_level;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic model_clear();
    q.delete();
    t = 0; front_ready = 0; push_total = 0; fetch_total = 0;
  endtask

  // Drives one cycle, captures DUT outputs and model expectations, advances the model.
  task automatic do_cycle(input logic wv, input logic [DW-1:0] wd, input logic rr);
    bit pop_m, push_m;
    @(negedge clk);
    wr_pvld = wv; wr_pd = wd; rd_prdy = rr;
    #1;
    obs_wr_prdy = wr_prdy; obs_rd_pvld = rd_pvld; obs_rd_pd = rd_pd;
    obs_we = ram_we; obs_wa = ram_wa; obs_di = ram_di;
    obs_re = ram_re; obs_ra = ram_ra; obs_level = fifo_level;

    exp_wr_prdy = (q.size() != DEPTH);
    exp_rd_pvld = (q.size() > 0) && (t >= front_ready);
    exp_rd_pd   = (q.size() > 0) ? q[0].d : '0;
    exp_we      = wv && exp_wr_prdy;
    exp_wa      = AW'(push_total % DEPTH);
    if (exp_rd_pvld) exp_re = rr && (q.size() > 1) && (q[1].pc + 2 <= t + 1);
    else             exp_re = (q.size() > 0) && (front_ready == t + 1);
    exp_ra      = AW'(fetch_total % DEPTH);
`ifdef NV_FIFO_CTRL_LEVEL_EN
    exp_level   = (AW+1)'(q.size());
`else
    exp_level   = '0;
`endif
    @(posedge clk);
    pop_m  = exp_rd_pvld && rr;
    push_m = exp_we;
    if (pop_m) begin
      void'(q.pop_front());
      if (q.size() > 0) front_ready = (q[0].pc + 2 > t + 1) ? q[0].pc + 2 : t + 1;
    end
    if (push_m) begin
      q.push_back('{d: wd, pc: t});
      if (q.size() == 1) front_ready = t + 2;
      push_total++;
    end
    if (exp_re) fetch_total++;
    t++;
  endtask

  task automatic start_reset();
    @(negedge clk);
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic end_reset();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wr_prdy !== 1'b1) begin n_fail++; $display("FAIL reset_wr_prdy got=%b want=1", wr_prdy); end
    n_cmp++; if (rd_pvld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_pvld got=%b want=0", rd_pvld); end
    end_reset();
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, '0, 1'b0);
      n_cmp++; if (obs_wr_prdy !== 1'b1 || obs_rd_pvld !== 1'b0 || obs_we !== 1'b0 || obs_re !== 1'b0 || obs_level !== '0) begin
        n_fail++; $display("FAIL idle prdy=%b pvld=%b we=%b re=%b lvl=%0d want 1 0 0 0 0", obs_wr_prdy, obs_rd_pvld, obs_we, obs_re, obs_level);
      end
    end
  endtask

  task automatic test_latency();
    do_cycle(1'b1, 32'hA5A50001, 1'b0);
    n_cmp++; if (obs_we !== 1'b1 || obs_wa !== 5'd0 || obs_di !== 32'hA5A50001) begin
      n_fail++; $display("FAIL lat_c0 we=%b wa=%0d di=%h want 1 0 a5a50001", obs_we, obs_wa, obs_di);
    end
    do_cycle(1'b0, '0, 1'b0);
    n_cmp++; if (obs_re !== 1'b1 || obs_ra !== 5'd0 || obs_rd_pvld !== 1'b0) begin
      n_fail++; $display("FAIL lat_c1 re=%b ra=%0d pvld=%b want 1 0 0", obs_re, obs_ra, obs_rd_pvld);
    end
    do_cycle(1'b0, '0, 1'b1);
    n_cmp++; if (obs_rd_pvld !== 1'b1 || obs_rd_pd !== 32'hA5A50001) begin
      n_fail++; $display("FAIL lat_c2 pvld=%b pd=%h want 1 a5a50001", obs_rd_pvld, obs_rd_pd);
    end
    do_cycle(1'b0, '0, 1'b0);
    n_cmp++; if (obs_rd_pvld !== 1'b0) begin n_fail++; $display("FAIL lat_empty pvld=%b want 0", obs_rd_pvld); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, DW'(i), 1'b0);
      n_cmp++; if (obs_wr_prdy !== 1'b1 || obs_we !== 1'b1 || obs_wa !== exp_wa || obs_level !== exp_level) begin
        n_fail++; $display("FAIL fill_%0d prdy=%b we=%b wa=%0d lvl=%0d want 1 1 %0d %0d", i, obs_wr_prdy, obs_we, obs_wa, obs_level, exp_wa, exp_level);
      end
    end
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 32'hDEAD0000, 1'b0);
      n_cmp++; if (obs_wr_prdy !== 1'b0 || obs_we !== 1'b0 || obs_level !== exp_level) begin
        n_fail++; $display("FAIL full_%0d prdy=%b we=%b lvl=%0d want 0 0 %0d", i, obs_wr_prdy, obs_we, obs_level, exp_level);
      end
      n_cmp++; if (obs_rd_pvld !== 1'b1 || obs_rd_pd !== 32'd0) begin
        n_fail++; $display("FAIL full_head_%0d pvld=%b pd=%h want 1 0", i, obs_rd_pvld, obs_rd_pd);
      end
    end
  endtask

  task automatic test_drain_full();
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 32'h1000 + DW'(i), 1'b1);
      if (i == 0) begin
        n_cmp++; if (obs_wr_prdy !== 1'b0 || obs_we !== 1'b0) begin
          n_fail++; $display("FAIL drain_pop_full prdy=%b we=%b want 0 0", obs_wr_prdy, obs_we);
        end
      end
      if (i == 1) begin
        n_cmp++; if (obs_wr_prdy !== 1'b1) begin n_fail++; $display("FAIL drain_prdy_rise got=%b want 1", obs_wr_prdy); end
      end
      n_cmp++; if (obs_rd_pvld !== exp_rd_pvld || (exp_rd_pvld && obs_rd_pd !== exp_rd_pd)) begin
        n_fail++; $display("FAIL drain_%0d pvld=%b pd=%h want %b %h", i, obs_rd_pvld, obs_rd_pd, exp_rd_pvld, exp_rd_pd);
      end
      n_cmp++; if (obs_wr_prdy !== exp_wr_prdy || obs_re !== exp_re || obs_ra !== exp_ra || obs_level !== exp_level) begin
        n_fail++; $display("FAIL drain_ctl_%0d prdy=%b re=%b ra=%0d lvl=%0d want %b %b %0d %0d", i, obs_wr_prdy, obs_re, obs_ra, obs_level, exp_wr_prdy, exp_re, exp_ra, exp_level);
      end
    end
    for (int i = 0; i < 80 && q.size() > 0; i++) begin
      do_cycle(1'b0, '0, 1'b1);
      n_cmp++; if (obs_rd_pvld !== exp_rd_pvld || (exp_rd_pvld && obs_rd_pd !== exp_rd_pd)) begin
        n_fail++; $display("FAIL flush_%0d pvld=%b pd=%h want %b %h", i, obs_rd_pvld, obs_rd_pd, exp_rd_pvld, exp_rd_pd);
      end
    end
    n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL flush_timeout left=%0d want 0", q.size()); end
  endtask

  task automatic test_stream();
    int pops = 0;
    for (int i = 0; i < 104; i++) begin
      do_cycle(i < 100, 32'h5000_0000 + DW'(i), 1'b1);
      if (obs_rd_pvld === 1'b1) pops++;
      n_cmp++; if (obs_rd_pvld !== exp_rd_pvld || (exp_rd_pvld && obs_rd_pd !== exp_rd_pd) || obs_wr_prdy !== 1'b1) begin
        n_fail++; $display("FAIL stream_%0d pvld=%b pd=%h prdy=%b want %b %h 1", i, obs_rd_pvld, obs_rd_pd, obs_wr_prdy, exp_rd_pvld, exp_rd_pd);
      end
      n_cmp++; if (obs_rd_pvld !== (i >= 2 && i < 102)) begin
        n_fail++; $display("FAIL stream_rate_%0d pvld=%b want %b", i, obs_rd_pvld, (i >= 2 && i < 102));
      end
    end
    n_cmp++; if (pops != 100) begin n_fail++; $display("FAIL stream_count got=%0d want 100", pops); end
  endtask

  task automatic test_random_stall();
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_pd = '0;
    for (int i = 0; i < 400; i++) begin
      logic wv, rr;
      wv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 9) < 4);
      do_cycle(wv, $urandom, rr);
      n_cmp++; if (obs_rd_pvld !== exp_rd_pvld || (exp_rd_pvld && obs_rd_pd !== exp_rd_pd)) begin
        n_fail++; $display("FAIL rnd_%0d pvld=%b pd=%h want %b %h", i, obs_rd_pvld, obs_rd_pd, exp_rd_pvld, exp_rd_pd);
      end
      n_cmp++; if (obs_wr_prdy !== exp_wr_prdy || obs_we !== exp_we || obs_wa !== exp_wa || obs_re !== exp_re || obs_ra !== exp_ra || obs_level !== exp_level) begin
        n_fail++; $display("FAIL rnd_ctl_%0d prdy=%b we=%b wa=%0d re=%b ra=%0d lvl=%0d want %b %b %0d %b %0d %0d", i,
          obs_wr_prdy, obs_we, obs_wa, obs_re, obs_ra, obs_level, exp_wr_prdy, exp_we, exp_wa, exp_re, exp_ra, exp_level);
      end
      if (prev_stall) begin
        n_cmp++; if (obs_rd_pd !== prev_pd) begin n_fail++; $display("FAIL stall_hold_%0d pd=%h want %h", i, obs_rd_pd, prev_pd); end
      end
      prev_stall = obs_rd_pvld && !rr;
      prev_pd    = obs_rd_pd;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'h7000_0000 + DW'(i), (i % 3) == 0);
    start_reset();
    n_cmp++; if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || fifo_level !== '0) begin
      n_fail++; $display("FAIL mid_reset pvld=%b prdy=%b lvl=%0d want 0 1 0", rd_pvld, wr_prdy, fifo_level);
    end
    end_reset();
    for (int i = 0; i < 8; i++) begin
      do_cycle(i < 3, 32'h9000_0000 + DW'(i), 1'b1);
      n_cmp++; if (obs_rd_pvld !== exp_rd_pvld || (exp_rd_pvld && obs_rd_pd !== exp_rd_pd) || obs_wa !== exp_wa || obs_ra !== exp_ra) begin
        n_fail++; $display("FAIL post_reset_%0d pvld=%b pd=%h wa=%0d ra=%0d want %b %h %0d %0d", i,
          obs_rd_pvld, obs_rd_pd, obs_wa, obs_ra, exp_rd_pvld, exp_rd_pd, exp_wa, exp_ra);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_drain_full();
    test_stream();
    test_random_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
